// File: rtl/vga_pixel_cache_if.sv
// Cache handshake bundle between the frame-store writer, the pixel cache and the VGA output stage.
// master = upstream writer / VGA reader side, slave = the cache itself.
interface vga_pixel_cache_if;
  logic        VSYNC;
  logic        WR_EN;
  logic [15:0] WR_DATA;
  logic        WR_READY;
  logic        FILL_REQ;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        CACHE_RD_EN;
  logic        CACHE_RREQ;
  logic [15:0] DATA_OUT;
  logic        UNDERFLOW;

  modport master (
    output VSYNC, WR_EN, WR_DATA, CACHE_RREQ,
    input  WR_READY, FILL_REQ, FRAME_START, FRAME_DONE, CACHE_RD_EN, DATA_OUT, UNDERFLOW
  );

  modport slave (
    input  VSYNC, WR_EN, WR_DATA, CACHE_RREQ,
    output WR_READY, FILL_REQ, FRAME_START, FRAME_DONE, CACHE_RD_EN, DATA_OUT, UNDERFLOW
  );
endinterface

// File: rtl/vga_pixel_cache.sv
// RGB565 first-word-fall-through pixel cache between the frame store and the VGA stage.
// Flushes and re-arms on every VSYNC falling edge; all status outputs are registered.
module vga_pixel_cache #(
  parameter int DEPTH        = 512,
  parameter int ADDR_W       = 9,
  parameter int FRAME_PIXELS = 76800,
  parameter int LOW_WM       = 128
) (
  input  logic              CLK_40M,
  input  logic              RST_N,
  vga_pixel_cache_if.slave  bus
);

  localparam int PIX_W = 17;
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  LOW_WM_C = (ADDR_W+1)'(LOW_WM);
  localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [PIX_W-1:0] FRAME_C  = PIX_W'(FRAME_PIXELS);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

  typedef enum logic {
    ST_WAIT_SYNC,
    ST_ARMED
  } state_e;

  logic [15:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic              vs_q, vs_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [15:0]       data_q, data_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_ready_q, wr_ready_d;
  logic              fill_req_q, fill_req_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              underflow_q, underflow_d;

  logic vs_fall;
  logic accept;
  logic pop;
  logic armed_d;

  always_comb begin
    vs_fall = vs_q & ~bus.VSYNC;
    accept  = bus.WR_EN & wr_ready_q & ~vs_fall;
    pop     = bus.CACHE_RREQ & rd_en_q & ~vs_fall;

    vs_d          = bus.VSYNC;
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pix_d         = pix_q;
    underflow_d   = underflow_q;
    frame_start_d = 1'b0;

    if (vs_fall) begin
      state_d       = ST_ARMED;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      pix_d         = '0;
      underflow_d   = 1'b0;
      frame_start_d = 1'b1;
    end else begin
      // wr_ready_q already excludes a saturated pixel counter, so no clamp is needed here
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        pix_d    = pix_q + PIX_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({accept, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      if (bus.CACHE_RREQ && !rd_en_q) underflow_d = 1'b1;
    end

    // Next head comes straight from WR_DATA when it is the word being written this cycle
    data_d = data_q;
    if (count_d != '0) begin
      if (accept && (rd_ptr_d == wr_ptr_q)) data_d = bus.WR_DATA;
      else                                  data_d = mem[rd_ptr_d[ADDR_W-1:0]];
    end

    armed_d      = (state_d == ST_ARMED);
    rd_en_d      = (count_d != '0);
    frame_done_d = (pix_d == FRAME_C);
    wr_ready_d   = armed_d & (count_d < DEPTH_C) & (pix_d < FRAME_C);
    fill_req_d   = armed_d & (count_d < LOW_WM_C) & ~frame_done_d;
  end

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_WAIT_SYNC;
      vs_q          <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pix_q         <= '0;
      data_q        <= '0;
      rd_en_q       <= 1'b0;
      wr_ready_q    <= 1'b0;
      fill_req_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pix_q         <= pix_d;
      data_q        <= data_d;
      rd_en_q       <= rd_en_d;
      wr_ready_q    <= wr_ready_d;
      fill_req_q    <= fill_req_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge CLK_40M) begin
    if (accept) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.WR_DATA;
  end

  assign bus.WR_READY    = wr_ready_q;
  assign bus.FILL_REQ    = fill_req_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.FRAME_DONE  = frame_done_q;
  assign bus.CACHE_RD_EN = rd_en_q;
  assign bus.DATA_OUT    = data_q;
  assign bus.UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_vga_pixel_cache.sv
// Scoreboard bench for vga_pixel_cache: accepted writes are queued, a negedge monitor
// checks DATA_OUT against the queue on every pop; directed checks cover the status flags.
`timescale 1ns/1ps
module tb_vga_pixel_cache;

  logic CLK_40M = 1'b0;
  logic RST_N   = 1'b0;

  vga_pixel_cache_if bus();

  vga_pixel_cache #(
    .DEPTH(512),
    .ADDR_W(9),
    .FRAME_PIXELS(76800),
    .LOW_WM(128)
  ) dut (
    .CLK_40M(CLK_40M),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #12.5 CLK_40M = ~CLK_40M;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  // Bench-side bookkeeping used only to decide which writes the cache should take
  bit m_armed = 1'b0;
  int m_count = 0;
  int m_pix   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK_40M) begin
    if (RST_N && bus.CACHE_RREQ === 1'b1 && bus.CACHE_RD_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_underrun: got %0h expected no data at %0t", bus.DATA_OUT, $time);
      end else begin
        check("pop_data", {16'h0, bus.DATA_OUT}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_400_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK_40M);
    #1;
  endtask

  task automatic step(input logic we, input logic [15:0] d, input logic rr);
    bit acc;
    bit pp;
    bus.WR_EN      = we;
    bus.WR_DATA    = d;
    bus.CACHE_RREQ = rr;
    acc = we && m_armed && (m_count < 512) && (m_pix < 76800);
    pp  = rr && (m_count > 0);
    if (acc) begin
      exp_q.push_back(d);
      m_count++;
      m_pix++;
    end
    if (pp) m_count--;
    tick();
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic vsync_pulse(input logic we_in_edge);
    bus.WR_EN      = we_in_edge;
    bus.WR_DATA    = 16'hDEAD;
    bus.CACHE_RREQ = 1'b0;
    bus.VSYNC      = 1'b0;
    tick();
    bus.WR_EN = 1'b0;
    m_armed = 1'b1;
    m_count = 0;
    m_pix   = 0;
    exp_q.delete();
    check("frame_start_high", {31'h0, bus.FRAME_START}, 32'h1);
    tick();
    check("frame_start_low", {31'h0, bus.FRAME_START}, 32'h0);
    tick();
    bus.VSYNC = 1'b1;
    tick();
  endtask

  initial begin
    bus.VSYNC      = 1'b1;
    bus.WR_EN      = 1'b0;
    bus.WR_DATA    = '0;
    bus.CACHE_RREQ = 1'b0;

    // Reset values
    #40;
    check("rst_data_out", {16'h0, bus.DATA_OUT}, 32'h0);
    check("rst_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);
    check("rst_wr_ready", {31'h0, bus.WR_READY}, 32'h0);
    check("rst_fill_req", {31'h0, bus.FILL_REQ}, 32'h0);
    check("rst_frame_start", {31'h0, bus.FRAME_START}, 32'h0);
    check("rst_frame_done", {31'h0, bus.FRAME_DONE}, 32'h0);
    check("rst_underflow", {31'h0, bus.UNDERFLOW}, 32'h0);
    @(posedge CLK_40M);
    #1;
    RST_N = 1'b1;
    tick();

    // Not armed yet: writes dropped, no requests
    step(1'b1, 16'h5555, 1'b0);
    idle();
    check("unarmed_wr_ready", {31'h0, bus.WR_READY}, 32'h0);
    check("unarmed_fill_req", {31'h0, bus.FILL_REQ}, 32'h0);
    check("unarmed_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);

    vsync_pulse(1'b0);
    check("armed_wr_ready", {31'h0, bus.WR_READY}, 32'h1);
    check("armed_fill_req", {31'h0, bus.FILL_REQ}, 32'h1);
    check("armed_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);

    // Three pixels, FWFT head, then pops
    step(1'b1, 16'hF800, 1'b0);
    check("fwft_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h1);
    check("fwft_head", {16'h0, bus.DATA_OUT}, 32'hF800);
    step(1'b1, 16'h07E0, 1'b0);
    step(1'b1, 16'h001F, 1'b0);
    check("head_held", {16'h0, bus.DATA_OUT}, 32'hF800);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    idle();
    check("drained_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);
    check("drained_data_hold", {16'h0, bus.DATA_OUT}, 32'h001F);

    // Fill to full, watermark and overflow drop
    for (int unsigned i = 0; i < 513; i++) begin
      step(1'b1, 16'(i), 1'b0);
      if (i == 126) check("fill_req_at_127", {31'h0, bus.FILL_REQ}, 32'h1);
      if (i == 127) check("fill_req_at_128", {31'h0, bus.FILL_REQ}, 32'h0);
      if (i == 510) check("wr_ready_at_511", {31'h0, bus.WR_READY}, 32'h1);
      if (i == 511) check("wr_ready_full", {31'h0, bus.WR_READY}, 32'h0);
    end
    check("full_after_drop", {31'h0, bus.WR_READY}, 32'h0);
    check("full_head", {16'h0, bus.DATA_OUT}, 32'h0);
    step(1'b0, 16'h0, 1'b1);
    check("wr_ready_after_pop", {31'h0, bus.WR_READY}, 32'h1);

    // Concurrent write and pop at 511 entries
    for (int unsigned i = 0; i < 100; i++) step(1'b1, 16'(512 + i), 1'b1);
    check("steady_wr_ready", {31'h0, bus.WR_READY}, 32'h1);
    check("steady_fill_req", {31'h0, bus.FILL_REQ}, 32'h0);
    check("steady_model_count", 32'(m_count), 32'd511);
    while (m_count > 0) step(1'b0, 16'h0, 1'b1);
    idle();
    check("empty_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);
    check("empty_fill_req", {31'h0, bus.FILL_REQ}, 32'h1);

    // Underflow, write alongside a pop on empty, clear on frame sync
    step(1'b0, 16'h0, 1'b1);
    check("underflow_set", {31'h0, bus.UNDERFLOW}, 32'h1);
    step(1'b1, 16'hABCD, 1'b1);
    check("uf_write_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h1);
    check("uf_write_head", {16'h0, bus.DATA_OUT}, 32'hABCD);
    step(1'b0, 16'h0, 1'b1);
    idle();
    check("underflow_sticky", {31'h0, bus.UNDERFLOW}, 32'h1);
    vsync_pulse(1'b0);
    check("underflow_cleared", {31'h0, bus.UNDERFLOW}, 32'h0);

    // Full frame stream with ten words held in flight
    for (int unsigned i = 0; i < 76800; i++) begin
      if (i == 76799) begin
        check("pre_done_frame_done", {31'h0, bus.FRAME_DONE}, 32'h0);
        check("pre_done_wr_ready", {31'h0, bus.WR_READY}, 32'h1);
      end
      step(1'b1, 16'(i), i >= 10);
    end
    check("frame_done", {31'h0, bus.FRAME_DONE}, 32'h1);
    check("done_wr_ready", {31'h0, bus.WR_READY}, 32'h0);
    check("done_fill_req", {31'h0, bus.FILL_REQ}, 32'h0);
    step(1'b1, 16'hBEEF, 1'b0);
    check("done_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h1);

    // Frame sync with data still buffered; write in the edge cycle is discarded
    vsync_pulse(1'b1);
    check("flush_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);
    check("flush_frame_done", {31'h0, bus.FRAME_DONE}, 32'h0);
    check("flush_wr_ready", {31'h0, bus.WR_READY}, 32'h1);
    check("flush_fill_req", {31'h0, bus.FILL_REQ}, 32'h1);
    step(1'b1, 16'h1234, 1'b0);
    check("post_flush_head", {16'h0, bus.DATA_OUT}, 32'h1234);
    step(1'b0, 16'h0, 1'b1);
    idle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-frame
    step(1'b1, 16'h4321, 1'b0);
    step(1'b1, 16'h8765, 1'b0);
    #5;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    m_armed = 1'b0;
    m_count = 0;
    m_pix   = 0;
    check("async_rst_data", {16'h0, bus.DATA_OUT}, 32'h0);
    check("async_rst_rd_en", {31'h0, bus.CACHE_RD_EN}, 32'h0);
    check("async_rst_wr_ready", {31'h0, bus.WR_READY}, 32'h0);
    @(posedge CLK_40M);
    #1;
    RST_N = 1'b1;
    for (int unsigned i = 0; i < 3; i++) idle();
    check("rearm_wait_wr_ready", {31'h0, bus.WR_READY}, 32'h0);
    vsync_pulse(1'b0);
    check("rearm_wr_ready", {31'h0, bus.WR_READY}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_cache.md
Name: vga_pixel_cache

Overview:
- Pixel cache feeding the VGA timing/output stage on CLK_40M.
- Buffers RGB565 pixels streamed from the frame store (SDRAM read port / capture path) in a synchronous first-word-fall-through FIFO.
- Serves them to the VGA stage through the cache handshake (data valid, read request, data).
- Realigns to each VGA frame by flushing on the VSYNC pulse and signalling the upstream to restart its frame read.

Parameters:
DEPTH, 512, FIFO depth in 16-bit words (power of two)
ADDR_W, 9, log2(DEPTH)
FRAME_PIXELS, 76800, pixels per frame (240 x 320)
LOW_WM, 128, fill-request watermark in words

Ports:
CLK_40M  in  1  pixel clock
RST_N  in  1  reset, asynchronous, active-low
VSYNC  in  1  VGA vertical sync (low during sync pulse)
WR_EN  in  1  upstream write strobe
WR_DATA  in  16  upstream RGB565 pixel
WR_READY  out  1  cache can accept a write this cycle
FILL_REQ  out  1  fill level below LOW_WM, upstream should burst
FRAME_START  out  1  one-cycle pulse: upstream restarts frame read address
FRAME_DONE  out  1  FRAME_PIXELS accepted this frame
CACHE_RD_EN  out  1  DATA_OUT valid (FIFO not empty)
CACHE_RREQ  in  1  VGA pops head pixel
DATA_OUT  out  16  head pixel to VGA DATA_IN
UNDERFLOW  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, RST_N low):
  - Pointers and count = 0; pixel counter = 0.
  - DATA_OUT = 16'h0, CACHE_RD_EN = 0, WR_READY = 0, FILL_REQ = 0, FRAME_START = 0, FRAME_DONE = 0, UNDERFLOW = 0.
  - VSYNC edge register = 1.
- After reset, first VSYNC falling edge required before operation. State ARMED = 0 until then. While ARMED = 0: WR_READY = 0, FILL_REQ = 0.
- Frame sync:
  - vs_d registers VSYNC; falling edge = vs_d & ~VSYNC.
  - On the edge: pointers, count, pixel counter and UNDERFLOW clear next cycle.
  - FRAME_START = 1 for exactly that next cycle; ARMED set.
  - Writes and pops in the edge cycle are discarded.
- Storage: DEPTH x 16 array; wr_ptr/rd_ptr ADDR_W+1 bits wrap naturally; count 0..DEPTH (ADDR_W+1 bits).
- Write:
  - WR_READY = ARMED & (count < DEPTH) & (pix_cnt < FRAME_PIXELS), registered-state only, no combinational path from CACHE_RREQ.
  - Accept = WR_EN & WR_READY.
  - WR_EN while not ready: word dropped silently; upstream must hold.
- Pixel counter (17 bits): increments per accepted write; saturates at FRAME_PIXELS. FRAME_DONE = (pix_cnt == FRAME_PIXELS).
- Read (FWFT):
  - CACHE_RD_EN = (count != 0); DATA_OUT = mem[rd_ptr] registered so it is valid whenever CACHE_RD_EN = 1.
  - Pop = CACHE_RREQ & CACHE_RD_EN; next head appears the following cycle.
  - First word written to an empty FIFO: CACHE_RD_EN rises 1 cycle after the accepting edge (write-to-read latency 1).
  - DATA_OUT holds its last value when empty.
- Simultaneous accept and pop: count unchanged. Accept at count == DEPTH is impossible; pop frees space visible next cycle.
- Empty + CACHE_RREQ: ignored, UNDERFLOW set (sticky until next frame sync). A write in the same cycle is still accepted.
- FILL_REQ = ARMED & (count < LOW_WM) & ~FRAME_DONE, registered.
- Reset mid-frame: immediate clear; re-arm on next VSYNC falling edge.

Test Plan:
- Reset, then VSYNC 1->0 -> FRAME_START high exactly 1 cycle; WR_READY = 1, FILL_REQ = 1, CACHE_RD_EN = 0.
- Write 16'hF800, 16'h07E0, 16'h001F with no pops -> CACHE_RD_EN = 1 one cycle after first write, DATA_OUT = F800. Pops with CACHE_RREQ return 07E0 then 001F. CACHE_RD_EN drops after third pop.
- Write continuously without pops -> WR_READY = 0 at count 512. 513th word dropped. FILL_REQ = 0 from count 128 onward. Pop once -> WR_READY = 1 next cycle.
- Simultaneous write/pop at count 511 for 100 cycles -> count stays 511, data order preserved (incrementing pattern checked).
- Pop on empty -> UNDERFLOW = 1, pointers unchanged. Next VSYNC falling edge -> UNDERFLOW = 0.
- Stream 76800 writes with steady pops -> FRAME_DONE = 1 after 76800th accept, WR_READY = 0, FILL_REQ = 0. VSYNC edge mid-FIFO-occupancy -> count = 0, FRAME_DONE = 0, FRAME_START pulse.
